// File: rtl/week_5_pla_result_capture_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : week_5_pla_result_capture_if                                |
// | Brief    : PLA sample in / tally report out bundle for result capture  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface week_5_pla_result_capture_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic             in_valid;
  logic             Y;
  logic             Z;
  logic             out_ready;
  logic             busy;
  logic             out_valid;
  logic [CNT_W-1:0] y_count;
  logic [CNT_W-1:0] z_count;
  logic [CNT_W-1:0] none_count;
  logic [CNT_W-1:0] both_count;
  logic             excl_err;

  // master: stimulus source and report consumer
  modport master (
    output start, in_valid, Y, Z, out_ready,
    input  busy, out_valid, y_count, z_count, none_count, both_count, excl_err
  );

  // slave: the capture stage itself
  modport slave (
    input  start, in_valid, Y, Z, out_ready,
    output busy, out_valid, y_count, z_count, none_count, both_count, excl_err
  );
endinterface
`default_nettype wire

// File: rtl/week_5_pla_result_capture.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : week_5_pla_result_capture                                   |
// | Brief    : Tallies WINDOW PLA Y/Z samples by class, reports via v/r.   |
// |            Define PLA_EXCL_CHECK_EN to enable the sticky excl_err flag.|
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module week_5_pla_result_capture #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 5
) (
  input  wire                               clk,
  input  wire                               rst_n,
  week_5_pla_result_capture_if.slave        bus
);

  localparam logic [CNT_W-1:0] c_last_idx = CNT_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_REPORT  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_idx;
  logic [CNT_W-1:0] r_y_count;
  logic [CNT_W-1:0] r_z_count;
  logic [CNT_W-1:0] r_none_count;
  logic [CNT_W-1:0] r_both_count;
  logic             r_busy;
  logic             r_out_valid;
`ifdef PLA_EXCL_CHECK_EN
  logic             r_excl_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_y_count    <= '0;
      r_z_count    <= '0;
      r_none_count <= '0;
      r_both_count <= '0;
      r_busy       <= 1'b0;
      r_out_valid  <= 1'b0;
`ifdef PLA_EXCL_CHECK_EN
      r_excl_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_idx        <= '0;
            r_y_count    <= '0;
            r_z_count    <= '0;
            r_none_count <= '0;
            r_both_count <= '0;
            r_busy       <= 1'b1;
            r_state      <= S_COLLECT;
`ifdef PLA_EXCL_CHECK_EN
            r_excl_err   <= 1'b0;
`endif
          end
        end
        S_COLLECT: begin
          if (bus.in_valid) begin
            case ({bus.Y, bus.Z})
              2'b10:   r_y_count    <= r_y_count + 1'b1;
              2'b01:   r_z_count    <= r_z_count + 1'b1;
              2'b00:   r_none_count <= r_none_count + 1'b1;
              default: r_both_count <= r_both_count + 1'b1;
            endcase
`ifdef PLA_EXCL_CHECK_EN
            if (bus.Y && bus.Z) begin
              r_excl_err <= 1'b1;
            end
`endif
            r_idx <= r_idx + 1'b1;
            // the WINDOW-th sample closes the run on this same edge
            if (r_idx == c_last_idx) begin
              r_out_valid <= 1'b1;
              r_state     <= S_REPORT;
            end
          end
        end
        S_REPORT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.out_valid  = r_out_valid;
  assign bus.y_count    = r_y_count;
  assign bus.z_count    = r_z_count;
  assign bus.none_count = r_none_count;
  assign bus.both_count = r_both_count;
`ifdef PLA_EXCL_CHECK_EN
  assign bus.excl_err   = r_excl_err;
`else
  assign bus.excl_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/week_5_pla_result_capture.md
Name: week_5_pla_result_capture

Overview:
- Downstream stage of the Drawing 02 PLA circuit, which has inputs A, B, C, D and outputs Y, Z.
- Samples the PLA's Y/Z outputs over a fixed window of valid cycles and classifies each sample as Y-only, Z-only, neither or both.
- Presents the four tallies to a consumer through a valid/ready handshake.
- Used as the result-collection stage in sequential labs that drive the PLA from a stimulus source.

Parameters:
- WINDOW, 16: number of accepted samples per capture run; legal range 1..(2^CNT_W - 1).
- CNT_W, 5: width of each tally counter; must hold the value WINDOW.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin a capture run; honoured only in IDLE.
- in_valid  input  1  Y/Z are a valid sample this cycle.
- Y  input  1  PLA output Y.
- Z  input  1  PLA output Z.
- out_ready  input  1  consumer accepts the report.
- busy  output  1  high in COLLECT and REPORT.
- out_valid  output  1  report available; high only in REPORT.
- y_count  output  CNT_W  number of samples with Y=1, Z=0.
- z_count  output  CNT_W  number of samples with Y=0, Z=1.
- none_count  output  CNT_W  number of samples with Y=0, Z=0.
- both_count  output  CNT_W  number of samples with Y=1, Z=1 (illegal PLA output).
- excl_err  output  1  sticky exclusivity error (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, out_valid=0, excl_err=0; all counts and the internal sample index are 0. Reset asserted mid-run aborts immediately and out_valid drops without waiting for a clock edge.
- States: IDLE, COLLECT, REPORT. Registered Moore outputs.
- IDLE:
  - start=1 at an edge: clears all counts, the sample index and excl_err, then enters COLLECT.
  - in_valid is ignored in IDLE.
  - Counts keep the last report's values until the next start.
- COLLECT:
  - Each edge with in_valid=1 increments exactly one tally, selected by {Y,Z}: 10 -> y_count, 01 -> z_count, 00 -> none_count, 11 -> both_count.
  - The same edge increments the sample index.
  - Cycles with in_valid=0 change nothing; gaps of any length are legal.
  - start is ignored.
  - On the edge that accepts the WINDOW-th sample, the state moves to REPORT, so out_valid=1 in the following cycle (latency 1 after the last sample).
- REPORT:
  - out_valid=1; counts held stable.
  - in_valid and start are ignored.
  - A transfer occurs on an edge with out_valid=1 and out_ready=1; the state then returns to IDLE and out_valid=0 the next cycle.
  - out_ready may be held high before out_valid rises; the transfer then happens on the first REPORT edge.
  - start asserted in the same cycle as the transfer is ignored; a new run needs start while in IDLE.
- Invariant at report: y_count + z_count + none_count + both_count == WINDOW.
- Counts never exceed WINDOW, so no overflow or wrap is possible.
- WINDOW=1: a single accepted sample moves COLLECT directly to REPORT.

Optional Feature:
- Macro: PLA_EXCL_CHECK_EN.
- Defined:
  - excl_err goes high the cycle after any accepted COLLECT sample with Y=1 and Z=1.
  - It remains high through REPORT and IDLE until reset or the next honoured start.
- Undefined:
  - excl_err is tied to 0.
  - both_count is still maintained.

Test Plan (WINDOW=5):
- Reset: assert rst_n=0 mid-COLLECT between clock edges -> busy=0, out_valid=0 and all counts 0 immediately; after release the state is IDLE.
- Normal run: start, then drive PLA with ABCD=1111, 1110, 1011, 0101, 0000 (Y/Z = 10, 01, 10, 01, 10) and in_valid=1 each cycle -> out_valid=1 one cycle after the 5th sample, with y=3, z=2, none=0, both=0.
- Gaps and backpressure: same samples with in_valid=0 gaps of 0–3 cycles and out_ready held low for 4 cycles -> identical counts; out_valid and counts stable until out_ready=1, then IDLE one cycle later.
- Ignored controls: pulse start during COLLECT and during REPORT, and in_valid during IDLE/REPORT -> counts unchanged; only 5 samples counted.
- Illegal output: feed Y=Z=1 once plus 4x Y=Z=0 -> both=1, none=4. With PLA_EXCL_CHECK_EN, excl_err=1 from the next cycle until the next start; without the macro, excl_err stays 0.
- Back-to-back runs: handshake, then start the following cycle -> counts cleared at that edge; the second report is independent of the first.
